// File: rtl/branch_redirect_ctrl_if.sv
// Branch sequencer interface: bundles the ID-stage branch inputs, the hazard/flush controls,
// the fetch redirect handshake, the link-write port and the perf counters.
//   master : core side (drives ID fields, opnd_ready, flush, redirect_ready)
//   slave  : branch_redirect_ctrl (drives stall_d, redirect_*, link_*, counters)
interface branch_redirect_ctrl_if #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 32
);
  logic            id_valid;
  logic [5:0]      id_op;
  logic [4:0]      id_rt;
  logic [15:0]     id_imm;
  logic [PC_W-1:0] id_pc;
  logic [PC_W-1:0] rs_val;
  logic [PC_W-1:0] rt_val;
  logic            opnd_ready;
  logic            flush;
  logic            redirect_ready;

  logic             stall_d;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic             link_we;
  logic [4:0]       link_addr;
  logic [PC_W-1:0]  link_data;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output id_valid, id_op, id_rt, id_imm, id_pc, rs_val, rt_val,
    output opnd_ready, flush, redirect_ready,
    input  stall_d, redirect_valid, redirect_pc, link_we, link_addr, link_data,
    input  br_cnt, taken_cnt
  );

  modport slave (
    input  id_valid, id_op, id_rt, id_imm, id_pc, rs_val, rt_val,
    input  opnd_ready, flush, redirect_ready,
    output stall_d, redirect_valid, redirect_pc, link_we, link_addr, link_data,
    output br_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// ID-stage branch sequencer for the 5-stage MIPS core.
// Decodes conditional branches, stalls ID until forwarded operands are final, evaluates the
// condition and holds a PC-redirect request to fetch until accepted. Issues the $31 link write
// for bltzal/bgezal. The delay slot proceeds while the redirect is outstanding.
// Ports:
//   clk  : core clock
//   rst  : asynchronous reset, active-high
//   bus  : branch_redirect_ctrl_if.slave (ID fields, operands, opnd_ready, flush, redirect
//          handshake, link write, perf counters)
// Optional feature: define BRANCH_PERF_EN to build the saturating br_cnt/taken_cnt counters;
// otherwise both counters are tied to 0.
module branch_redirect_ctrl #(
  parameter int unsigned PC_W     = 32,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned LINK_REG = 31
) (
  input logic               clk,
  input logic               rst,
  branch_redirect_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StWaitOpnd, StRedirect} state_e;

  state_e state_q, state_d;

  logic            is_br_op;
  logic            is_al;
  logic            cond;
  logic            branch;
  logic            rs_zero;
  logic            rs_neg;
  logic [PC_W-1:0] br_offset;
  logic [PC_W-1:0] target;

  logic stall_d;
  logic redirect_valid;
  logic eval;

  logic [PC_W-1:0] redirect_pc_q;
  logic            link_we_q;
  logic [PC_W-1:0] link_data_q;

  // ---------------------------------------------------------------------------
  // Decode and condition evaluation
  // ---------------------------------------------------------------------------
  assign rs_zero = (bus.rs_val == '0);
  assign rs_neg  = bus.rs_val[PC_W-1];

  always_comb begin
    is_br_op = 1'b0;
    is_al    = 1'b0;
    cond     = 1'b0;
    case (bus.id_op)
      6'b000100: begin is_br_op = 1'b1; cond = (bus.rs_val == bus.rt_val); end
      6'b000101: begin is_br_op = 1'b1; cond = (bus.rs_val != bus.rt_val); end
      6'b000110: begin is_br_op = 1'b1; cond = rs_neg | rs_zero; end
      6'b000111: begin is_br_op = 1'b1; cond = !rs_neg && !rs_zero; end
      6'b000001: begin
        // REGIMM: rt[0] selects >=0 vs <0, rt[4] selects the linking form
        case (bus.id_rt)
          5'b00000: begin is_br_op = 1'b1; cond = rs_neg; end
          5'b10000: begin is_br_op = 1'b1; cond = rs_neg; is_al = 1'b1; end
          5'b00001: begin is_br_op = 1'b1; cond = !rs_neg; end
          5'b10001: begin is_br_op = 1'b1; cond = !rs_neg; is_al = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign branch    = bus.id_valid && is_br_op;
  assign br_offset = {{(PC_W-18){bus.id_imm[15]}}, bus.id_imm, 2'b00};
  assign target    = bus.id_pc + PC_W'(4) + br_offset;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StWaitOpnd: begin
          if (!branch) begin
            state_d = StIdle;
          end else if (!bus.opnd_ready) begin
            state_d = StWaitOpnd;
          end else if (cond) begin
            state_d = StRedirect;
          end else begin
            state_d = StIdle;
          end
        end
        StRedirect: begin
          if (bus.redirect_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    stall_d        = 1'b0;
    redirect_valid = 1'b0;
    eval           = 1'b0;
    case (state_q)
      StIdle, StWaitOpnd: begin
        stall_d = branch && !bus.opnd_ready;
        // a flushed evaluation has no side effects (no redirect, link or count)
        eval    = branch && bus.opnd_ready && !bus.flush;
      end
      StRedirect: begin
        redirect_valid = 1'b1;
        // a branch sitting in the delay slot waits until the redirect retires
        stall_d        = branch;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Redirect target and link write
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_pc_q <= '0;
      link_we_q     <= 1'b0;
      link_data_q   <= '0;
    end else begin
      link_we_q <= eval && is_al;
      if (eval && cond) redirect_pc_q <= target;
      if (eval && is_al) link_data_q <= bus.id_pc + PC_W'(8);
    end
  end

  assign bus.stall_d        = stall_d;
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.link_we        = link_we_q;
  assign bus.link_addr      = 5'(LINK_REG);
  assign bus.link_data      = link_data_q;

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef BRANCH_PERF_EN
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] taken_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else if (eval) begin
      if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + CNT_W'(1);
      if (cond && (taken_cnt_q != '1)) taken_cnt_q <= taken_cnt_q + CNT_W'(1);
    end
  end

  assign bus.br_cnt    = br_cnt_q;
  assign bus.taken_cnt = taken_cnt_q;
`else
  assign bus.br_cnt    = '0;
  assign bus.taken_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
module tb_branch_redirect_ctrl;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 4;
`ifdef BRANCH_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_redirect_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  branch_redirect_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .LINK_REG(31)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference rules ----------------
  function automatic bit ref_is_branch(input logic [5:0] op, input logic [4:0] rt);
    if (op inside {6'd4, 6'd5, 6'd6, 6'd7}) return 1'b1;
    return (op == 6'd1) && (rt inside {5'd0, 5'd1, 5'd16, 5'd17});
  endfunction

  function automatic bit ref_taken(input logic [5:0] op, input logic [4:0] rt,
                                   input logic [31:0] rs, input logic [31:0] rtv);
    int s;
    s = $signed(rs);
    case (op)
      6'd4:    return rs == rtv;
      6'd5:    return rs != rtv;
      6'd6:    return s <= 0;
      6'd7:    return s > 0;
      default: return rt[0] ? (s >= 0) : (s < 0);
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [15:0] imm);
    int off;
    off = int'($signed(imm)) * 4;
    return pc + 32'd4 + 32'(off);
  endfunction

  function automatic logic [63:0] ref_cnt(input int n);
    if (!PerfEn) return 64'd0;
    return (n > 15) ? 64'd15 : 64'(n);
  endfunction

  // ---------------- drive helpers ----------------
  task automatic idle_in();
    bus.id_valid = 1'b0; bus.id_op = '0; bus.id_rt = '0; bus.id_imm = '0; bus.id_pc = '0;
    bus.rs_val = '0; bus.rt_val = '0; bus.opnd_ready = 1'b0; bus.flush = 1'b0;
    bus.redirect_ready = 1'b0;
  endtask

  task automatic drive_br(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm,
                          input logic [31:0] pc, input logic [31:0] rs, input logic [31:0] rtv,
                          input logic rdy);
    bus.id_valid = 1'b1; bus.id_op = op; bus.id_rt = rt; bus.id_imm = imm; bus.id_pc = pc;
    bus.rs_val = rs; bus.rt_val = rtv; bus.opnd_ready = rdy;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rtv;
    bit          taken;
    logic [31:0] tgt;
    bit          al;
  } vec_t;

  vec_t tbl[17];

  task automatic apply_vec(input int i);
    @(negedge clk);
    drive_br(tbl[i].op, tbl[i].rt, tbl[i].imm, tbl[i].pc, tbl[i].rs, tbl[i].rtv, 1'b1);
    bus.redirect_ready = 1'b0;
    #1 check($sformatf("tbl%0d stall", i), bus.stall_d, 0);
    @(negedge clk);
    bus.id_valid = 1'b0; bus.redirect_ready = 1'b1;
    #1 check($sformatf("tbl%0d redirect_valid", i), bus.redirect_valid, tbl[i].taken);
    if (tbl[i].taken) check($sformatf("tbl%0d redirect_pc", i), bus.redirect_pc, tbl[i].tgt);
    check($sformatf("tbl%0d link_we", i), bus.link_we, tbl[i].al);
    if (tbl[i].al) check($sformatf("tbl%0d link_data", i), bus.link_data, tbl[i].pc + 32'd8);
    @(negedge clk);
    bus.redirect_ready = 1'b0;
    #1 check($sformatf("tbl%0d valid drop", i), bus.redirect_valid, 0);
    check($sformatf("tbl%0d link_we drop", i), bus.link_we, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_in();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // random-phase model state
  bit          pend, link_exp, hold, br, exp_stall, ev, tk;
  logic [31:0] pend_pc, link_data_exp;
  int          cnt_br, cnt_tk;
  logic [5:0]  op_list[8] = '{6'd0, 6'd1, 6'd1, 6'd4, 6'd5, 6'd6, 6'd7, 6'h23};
  logic [4:0]  rt_list[5] = '{5'd0, 5'd1, 5'd16, 5'd17, 5'd2};
  logic [31:0] rs_list[4] = '{32'd0, 32'h8000_0000, 32'd5, 32'hFFFF_FFFF};

  initial begin
    tbl[0]  = '{6'd4, 5'd0,  16'h0004, 32'h100,       32'd5,         32'd5, 1, 32'h114,       0};
    tbl[1]  = '{6'd5, 5'd0,  16'h0004, 32'h100,       32'd5,         32'd5, 0, 32'h0,         0};
    tbl[2]  = '{6'd5, 5'd0,  16'hFFFE, 32'h1000,      32'd1,         32'd2, 1, 32'hFFC,       0};
    tbl[3]  = '{6'd6, 5'd0,  16'h0010, 32'h40,        32'd0,         32'd9, 1, 32'h84,        0};
    tbl[4]  = '{6'd6, 5'd0,  16'h0010, 32'h40,        32'd1,         32'd0, 0, 32'h0,         0};
    tbl[5]  = '{6'd6, 5'd0,  16'h0001, 32'h0,         32'h8000_0000, 32'd0, 1, 32'h8,         0};
    tbl[6]  = '{6'd7, 5'd0,  16'h0002, 32'h20,        32'd1,         32'd0, 1, 32'h2C,        0};
    tbl[7]  = '{6'd7, 5'd0,  16'h0002, 32'h20,        32'hFFFF_FFFF, 32'd0, 0, 32'h0,         0};
    tbl[8]  = '{6'd1, 5'd16, 16'hFFFF, 32'h200,       32'h8000_0000, 32'd0, 1, 32'h200,       1};
    tbl[9]  = '{6'd1, 5'd17, 16'h0004, 32'h300,       32'h8000_0000, 32'd0, 0, 32'h0,         1};
    tbl[10] = '{6'd1, 5'd1,  16'h0000, 32'h10,        32'd7,         32'd0, 1, 32'h14,        0};
    tbl[11] = '{6'd1, 5'd2,  16'h0004, 32'h10,        32'h8000_0000, 32'd0, 0, 32'h0,         0};
    tbl[12] = '{6'h23, 5'd0, 16'h0004, 32'h10,        32'd0,         32'd0, 0, 32'h0,         0};
    tbl[13] = '{6'd4, 5'd0,  16'h0001, 32'hFFFF_FFF8, 32'd0,         32'd0, 1, 32'h0,         0};
    tbl[14] = '{6'd1, 5'd17, 16'h0100, 32'h400,       32'd0,         32'd0, 1, 32'h804,       1};
    tbl[15] = '{6'd1, 5'd0,  16'h8000, 32'h8,         32'hFFFF_FFFF, 32'd0, 1, 32'hFFFE_000C, 0};
    tbl[16] = '{6'd1, 5'd0,  16'h0004, 32'h8,         32'd5,         32'd0, 0, 32'h0,         0};

    idle_in();
    rst = 1'b1;
    #12;
    check("rst stall_d", bus.stall_d, 0);
    check("rst redirect_valid", bus.redirect_valid, 0);
    check("rst redirect_pc", bus.redirect_pc, 0);
    check("rst link_we", bus.link_we, 0);
    check("rst link_addr", bus.link_addr, 31);
    check("rst link_data", bus.link_data, 0);
    check("rst br_cnt", bus.br_cnt, 0);
    check("rst taken_cnt", bus.taken_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // three taken and two not-taken evaluations from reset
    apply_vec(0); apply_vec(1); apply_vec(2); apply_vec(4); apply_vec(3);
    #1 check("perf br_cnt", bus.br_cnt, PerfEn ? 5 : 0);
    check("perf taken_cnt", bus.taken_cnt, PerfEn ? 3 : 0);

    for (int i = 5; i < 17; i++) apply_vec(i);

    // bgez waiting three cycles for operands
    @(negedge clk);
    drive_br(6'd1, 5'd1, 16'h0003, 32'h500, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 check("wait stall", bus.stall_d, 1);
      check("wait no redirect", bus.redirect_valid, 0);
      @(negedge clk);
    end
    bus.opnd_ready = 1'b1;
    #1 check("wait eval stall", bus.stall_d, 0);
    @(negedge clk);
    bus.id_valid = 1'b0; bus.redirect_ready = 1'b1;
    #1 check("wait redirect_valid", bus.redirect_valid, 1);
    check("wait redirect_pc", bus.redirect_pc, 32'h510);
    @(negedge clk);
    bus.redirect_ready = 1'b0;
    #1 check("wait valid drop", bus.redirect_valid, 0);

    // redirect held with non-branch delay slot, then flushed
    @(negedge clk);
    drive_br(6'd4, 5'd0, 16'h0004, 32'h100, 32'd5, 32'd5, 1'b1);
    @(negedge clk);
    bus.id_op = 6'h23;
    for (int i = 0; i < 4; i++) begin
      #1 check("hold valid", bus.redirect_valid, 1);
      check("hold pc", bus.redirect_pc, 32'h114);
      check("hold slot stall", bus.stall_d, 0);
      @(negedge clk);
    end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0; bus.id_valid = 1'b0;
    #1 check("flush drops valid", bus.redirect_valid, 0);

    // branch in delay slot stalls until redirect retires, then evaluates
    @(negedge clk);
    drive_br(6'd4, 5'd0, 16'h0004, 32'h100, 32'd5, 32'd5, 1'b1);
    @(negedge clk);
    drive_br(6'd5, 5'd0, 16'h0008, 32'h104, 32'd1, 32'd2, 1'b1);
    #1 check("slot br stall", bus.stall_d, 1);
    @(negedge clk);
    bus.redirect_ready = 1'b1;
    #1 check("slot br stall accept", bus.stall_d, 1);
    @(negedge clk);
    bus.redirect_ready = 1'b0;
    #1 check("slot br eval stall", bus.stall_d, 0);
    check("slot br idle", bus.redirect_valid, 0);
    @(negedge clk);
    bus.id_valid = 1'b0; bus.redirect_ready = 1'b1;
    #1 check("slot br redirect", bus.redirect_valid, 1);
    check("slot br pc", bus.redirect_pc, 32'h128);
    @(negedge clk);
    bus.redirect_ready = 1'b0;

    // flush on the evaluation cycle suppresses link and redirect
    @(negedge clk);
    drive_br(6'd1, 5'd16, 16'h0004, 32'h600, 32'h8000_0000, 32'd0, 1'b1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0; bus.id_valid = 1'b0;
    #1 check("flush link_we", bus.link_we, 0);
    check("flush no redirect", bus.redirect_valid, 0);

    // async reset mid-redirect
    @(negedge clk);
    drive_br(6'd4, 5'd0, 16'h0004, 32'h100, 32'd5, 32'd5, 1'b1);
    @(negedge clk);
    bus.id_valid = 1'b0;
    #1 check("pre-rst valid", bus.redirect_valid, 1);
    #1 rst = 1'b1;
    #1 check("async rst valid", bus.redirect_valid, 0);
    check("async rst pc", bus.redirect_pc, 0);
    @(negedge clk);
    rst = 1'b0;

    // randomized run against the reference model
    do_reset();
    pend = 0; link_exp = 0; hold = 0; pend_pc = '0; link_data_exp = '0; cnt_br = 0; cnt_tk = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (!hold) begin
        bus.id_valid = ($urandom_range(0, 7) != 0);
        bus.id_op    = op_list[$urandom_range(0, 7)];
        bus.id_rt    = rt_list[$urandom_range(0, 4)];
        bus.id_imm   = 16'($urandom);
        bus.id_pc    = $urandom & 32'hFFFF_FFFC;
        bus.rs_val   = ($urandom_range(0, 4) == 4) ? $urandom : rs_list[$urandom_range(0, 3)];
        bus.rt_val   = ($urandom_range(0, 1) == 0) ? bus.rs_val : $urandom;
      end
      bus.opnd_ready     = ($urandom_range(0, 2) != 0);
      bus.flush          = ($urandom_range(0, 15) == 0);
      bus.redirect_ready = ($urandom_range(0, 2) == 0);
      #1;
      br        = bus.id_valid && ref_is_branch(bus.id_op, bus.id_rt);
      exp_stall = br && (pend || !bus.opnd_ready);
      check("rnd stall_d", bus.stall_d, exp_stall);
      check("rnd redirect_valid", bus.redirect_valid, pend);
      if (pend) check("rnd redirect_pc", bus.redirect_pc, pend_pc);
      check("rnd link_we", bus.link_we, link_exp);
      if (link_exp) check("rnd link_data", bus.link_data, link_data_exp);
      check("rnd br_cnt", bus.br_cnt, ref_cnt(cnt_br));
      check("rnd taken_cnt", bus.taken_cnt, ref_cnt(cnt_tk));

      ev       = br && bus.opnd_ready && !pend && !bus.flush;
      tk       = ev && ref_taken(bus.id_op, bus.id_rt, bus.rs_val, bus.rt_val);
      link_exp = ev && (bus.id_op == 6'd1) && bus.id_rt[4];
      if (link_exp) link_data_exp = bus.id_pc + 32'd8;
      if (ev) cnt_br++;
      if (tk) cnt_tk++;
      if (bus.flush) pend = 0;
      else if (pend && bus.redirect_ready) pend = 0;
      else if (tk) begin
        pend    = 1;
        pend_pc = ref_target(bus.id_pc, bus.id_imm);
      end
      hold = exp_stall;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
